// File: rtl/acc_wrapp_pkg.sv
// Shared pipe types, accumulator state encoding and signed clip helpers
// for the accumulation stage that follows the systolic-array multiplier.
package acc_wrapp_pkg;

    typedef enum logic [1:0] {
        FIXED_POINT_GENERIC = 2'd0,
        FIXED_POINT_FRAC    = 2'd1,
        INT_ONLY            = 2'd2
    } arith_type_t;

    typedef struct packed {
        int int_wdt;
        int frac_wdt;
    } fxp_cfg_t;

    typedef struct packed {
        int          word_wdt;
        fxp_cfg_t    fxp_cfg;
        arith_type_t arith_type;
        logic        arith_satur;
    } arith_cfg_t;

    localparam arith_cfg_t C_ARITH_CFG_DEF = '{
        word_wdt:    16,
        fxp_cfg:     '{int_wdt: 8, frac_wdt: 8},
        arith_type:  FIXED_POINT_GENERIC,
        arith_satur: 1'b1
    };

    localparam int C_PIPE_WORD_WDT      = 16;
    localparam int C_PIPE_DATA_TYPE_WDT = 2;

    typedef struct packed {
        logic [C_PIPE_WORD_WDT-1:0]      data_word;
        logic                            data_val;
        logic [C_PIPE_DATA_TYPE_WDT-1:0] data_type;
        logic                            data_last;
    } pipe_data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    function automatic int acc_wdt_calc(input int word_wdt, input int guard_wdt);
        return word_wdt + guard_wdt;
    endfunction

    // Reinterpret the low in_wdt bits of val as a signed number.
    function automatic logic signed [63:0] sext_to64(input logic signed [63:0] val, input int in_wdt);
        return (val <<< (64 - in_wdt)) >>> (64 - in_wdt);
    endfunction

    function automatic logic satur_flag(input logic signed [63:0] val, input int in_wdt,
                                        input int out_wdt);
        logic signed [63:0] v;
        logic signed [63:0] lim;
        v   = sext_to64(val, in_wdt);
        lim = 64'sd1 <<< (out_wdt - 1);
        return (v >= lim) || (v < -lim);
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] val, input int in_wdt,
                                                    input int out_wdt);
        logic signed [63:0] v;
        logic signed [63:0] lim;
        v   = sext_to64(val, in_wdt);
        lim = 64'sd1 <<< (out_wdt - 1);
        if (v >= lim) begin
            return lim - 64'sd1;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/acc_wrapp_del_chain.sv
// Enable-gated delay line of DEL_CYC_LEN registers; zero length is a wire.
module del_chain #(
    parameter int WORD_WDT    = 1,
    parameter int DEL_CYC_LEN = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [WORD_WDT-1:0] din,
    output logic [WORD_WDT-1:0] dout
);

    generate
        if (DEL_CYC_LEN == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n ^ clk_en;
            assign dout        = din;
        end else begin : g_del
            logic [WORD_WDT-1:0] del_q [DEL_CYC_LEN];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEL_CYC_LEN; i++) begin
                        del_q[i] <= '0;
                    end
                end else if (clk_en) begin
                    del_q[0] <= din;
                    for (int i = 1; i < DEL_CYC_LEN; i++) begin
                        del_q[i] <= del_q[i-1];
                    end
                end
            end

            assign dout = del_q[DEL_CYC_LEN-1];
        end
    endgenerate

endmodule

// File: rtl/acc_wrapp.sv
// Sums the valid products of one dot-product sequence in a guarded accumulator
// and emits one clipped result word, with term count, when data_last arrives.
module acc_wrapp
    import acc_wrapp_pkg::*;
#(
    parameter arith_cfg_t ACC_ARITH_CFG   = C_ARITH_CFG_DEF,
    parameter int         ACC_GUARD_WDT   = 8,
    parameter int         ACC_CNT_WDT     = 10,
    parameter int         ACC_OUT_CYC_LEN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  pipe_data_t             acc_in,
    output pipe_data_t             acc_res,
    output logic [ACC_CNT_WDT-1:0] acc_len,
    output logic                   acc_ovf,
    output logic                   acc_type_err
);

    localparam int W       = ACC_ARITH_CFG.word_wdt;
    localparam int ACC_WDT = acc_wdt_calc(W, ACC_GUARD_WDT);
    localparam bit SATUR   = ACC_ARITH_CFG.arith_satur;
    localparam int TW      = C_PIPE_DATA_TYPE_WDT;

    typedef struct packed {
        logic [W-1:0]           word;
        logic [TW-1:0]          dtype;
        logic [ACC_CNT_WDT-1:0] len;
        logic                   val;
    } res_t;

    localparam int RES_WDT = $bits(res_t);

    acc_state_t               state_q;
    logic [ACC_WDT-1:0]       acc_q;
    logic [ACC_CNT_WDT-1:0]   cnt_q;
    logic [TW-1:0]            type_q;
    logic                     ovf_q;
    logic                     type_err_q;
    res_t                     res_p0;
    res_t                     res_out;

    logic [ACC_WDT-1:0]       term_sx;
    logic [ACC_WDT-1:0]       acc_base;
    logic [ACC_WDT-1:0]       acc_sum;
    logic signed [63:0]       sum_wide;
    logic                     add_ovf;
    logic                     out_clip;
    logic [W-1:0]             res_word;
    logic [ACC_CNT_WDT-1:0]   cnt_nxt;
    logic [TW-1:0]            seq_type;

    always_comb begin
        term_sx  = {{ACC_GUARD_WDT{acc_in.data_word[W-1]}}, acc_in.data_word[W-1:0]};
        // An idle accumulator contributes zero, so the first term of a sequence
        // and a single-element sequence share the same adder path.
        acc_base = (state_q == ACCUM) ? acc_q : '0;
        sum_wide = {{(64-ACC_WDT){acc_base[ACC_WDT-1]}}, acc_base}
                 + {{(64-ACC_WDT){term_sx[ACC_WDT-1]}}, term_sx};

        add_ovf = 1'b0;
        acc_sum = sum_wide[ACC_WDT-1:0];
        if (SATUR) begin
            add_ovf = satur_flag(sum_wide, 64, ACC_WDT);
            acc_sum = ACC_WDT'(sat_clip(sum_wide, 64, ACC_WDT));
        end

        out_clip = 1'b0;
        res_word = acc_sum[W-1:0];
        if (SATUR) begin
            out_clip = satur_flag(64'(acc_sum), ACC_WDT, W);
            res_word = W'(sat_clip(64'(acc_sum), ACC_WDT, W));
        end

        if (state_q == IDLE) begin
            cnt_nxt = ACC_CNT_WDT'(1);
        end else if (&cnt_q) begin
            cnt_nxt = cnt_q;
        end else begin
            cnt_nxt = cnt_q + ACC_CNT_WDT'(1);
        end

        seq_type = (state_q == IDLE) ? acc_in.data_type : type_q;
    end

    // Stage p0: accumulate, and register the result word on data_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            type_q     <= '0;
            ovf_q      <= 1'b0;
            type_err_q <= 1'b0;
            res_p0     <= '0;
        end else if (clk_en) begin
            res_p0 <= '0;
            if (acc_in.data_val) begin
                if (state_q == ACCUM && acc_in.data_type != type_q) begin
                    type_err_q <= 1'b1;
                end
                if (add_ovf) begin
                    ovf_q <= 1'b1;
                end
                if (acc_in.data_last) begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    res_p0  <= '{word: res_word, dtype: seq_type, len: cnt_nxt, val: 1'b1};
                    if (out_clip) begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    state_q <= ACCUM;
                    acc_q   <= acc_sum;
                    cnt_q   <= cnt_nxt;
                    type_q  <= seq_type;
                end
            end
        end
    end

    // Stages p1..: optional extra output delay
    del_chain #(
        .WORD_WDT    (RES_WDT),
        .DEL_CYC_LEN (ACC_OUT_CYC_LEN - 1)
    ) u_out_del (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .din    (res_p0),
        .dout   (res_out)
    );

    assign acc_res.data_word = C_PIPE_WORD_WDT'(res_out.word);
    assign acc_res.data_val  = res_out.val;
    assign acc_res.data_type = res_out.dtype;
    assign acc_res.data_last = res_out.val;
    assign acc_len           = res_out.len;
    assign acc_ovf           = ovf_q;
    assign acc_type_err      = type_err_q;

endmodule
